// File: rtl/pwm_rx_if.sv
// Signal bundle between the PWM demodulator and its consumer.
// The pwm_rx side is the master: it drives the measurement results and reads the line.
interface pwm_rx_if #(
    parameter int unsigned N = 5
);
    logic         pwm_in;
    logic [N-1:0] duty_out;
    logic [N-1:0] period_out;
    logic         valid_out;
    logic         stuck_out;
    logic         stuck_lvl_out;

    modport master (
        input  pwm_in,
        output duty_out,
        output period_out,
        output valid_out,
        output stuck_out,
        output stuck_lvl_out
    );

    modport slave (
        output pwm_in,
        input  duty_out,
        input  period_out,
        input  valid_out,
        input  stuck_out,
        input  stuck_lvl_out
    );
endinterface

// File: rtl/pwm_rx.sv
// PWM demodulator: measures high time and rise-to-rise period of an asynchronous PWM line
// in clock cycles, reports both once per period and flags a line that stopped toggling.
module pwm_rx #(
    parameter int unsigned N = 5
) (
    input  logic      clk_in,
    input  logic      rst,
    pwm_rx_if.master  bus
);

    localparam logic [N-1:0] MAX = '1;
    localparam logic [N-1:0] ONE = N'(1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArm     = 2'd1;
    localparam logic [1:0] StMeasure = 2'd2;
    localparam logic [1:0] StStuck   = 2'd3;

    logic         s1, s2, s3;
    logic [1:0]   primed;
    logic [N-1:0] per_cnt, hi_cnt;
    logic [1:0]   state_q, state_d;
    logic [N-1:0] duty_q, duty_d;
    logic [N-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         stuck_q, stuck_d;
    logic         lvl_q, lvl_d;

    logic rise, sat, real_low;

    assign rise = s2 & ~s3;
    assign sat  = (per_cnt == MAX);
    // s2 is only a genuine line sample once the cleared sync chain has refilled,
    // otherwise a line that is high at reset release would look like a fresh rise.
    assign real_low = primed[1] & ~s2;

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        lvl_d    = lvl_q;
        case (state_q)
            StIdle: begin
                if (real_low) begin
                    state_d = StArm;
                end else if (sat && !rise) begin
                    state_d = StStuck;
                    stuck_d = 1'b1;
                    lvl_d   = s2;
                end
            end
            StArm: begin
                if (rise) begin
                    state_d = StMeasure;
                end else if (sat) begin
                    state_d = StStuck;
                    stuck_d = 1'b1;
                    lvl_d   = s2;
                end
            end
            StMeasure: begin
                if (rise) begin
                    valid_d  = 1'b1;
                    duty_d   = hi_cnt;
                    period_d = per_cnt;
                end else if (sat) begin
                    state_d = StStuck;
                    stuck_d = 1'b1;
                    lvl_d   = s2;
                end
            end
            StStuck: begin
                if (rise) begin
                    state_d = StMeasure;
                    stuck_d = 1'b0;
                    lvl_d   = 1'b0;
                end else begin
                    lvl_d = s2;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            primed   <= 2'b00;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            state_q  <= StIdle;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            lvl_q    <= 1'b0;
        end else begin
            s1      <= bus.pwm_in;
            s2      <= s1;
            s3      <= s2;
            primed  <= {primed[0], 1'b1};
            if (rise) begin
                per_cnt <= ONE;
                hi_cnt  <= ONE;
            end else begin
                per_cnt <= sat ? MAX : per_cnt + ONE;
                hi_cnt  <= (s2 && hi_cnt != MAX) ? hi_cnt + ONE : hi_cnt;
            end
            state_q  <= state_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            lvl_q    <= lvl_d;
        end
    end

    assign bus.duty_out      = duty_q;
    assign bus.period_out    = period_q;
    assign bus.valid_out     = valid_q;
    assign bus.stuck_out     = stuck_q;
    assign bus.stuck_lvl_out = lvl_q;

endmodule

// File: tb/tb_pwm_rx.sv
// Bench for pwm_rx: directed and random PWM waveforms checked every cycle against a
// sample-indexed reference model of the measurement rules.
module tb_pwm_rx;

    localparam int MAXV = 31;

    typedef enum int {PhWaitLow, PhArmed, PhMeasuring, PhStuck} phase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_rx_if #(.N(5)) bus ();

    pwm_rx #(.N(5)) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobes = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: works on the list of line samples. A sample taken at edge k
    // shows its effect on the outputs after edge k+2.
    bit     started = 1'b0;
    bit     pend[$];
    phase_t ph;
    int     since;     // cycles since the last rise (reset counts as two cycles back)
    int     ones;      // high samples since the last rise
    bit     last;
    int     e_duty, e_period;
    bit     e_valid, e_stuck, e_lvl;
    bit     prev_valid;

    task automatic model_reset();
        pend.delete();
        ph       = PhWaitLow;
        since    = 2;
        ones     = 0;
        last     = 1'b0;
        e_duty   = 0;
        e_period = 0;
        e_valid  = 1'b0;
        e_stuck  = 1'b0;
        e_lvl    = 1'b0;
    endtask

    task automatic model_sample(input bit x);
        bit r;
        bit full;
        r       = x && !last;
        full    = (since >= MAXV);
        e_valid = 1'b0;
        case (ph)
            PhWaitLow: begin
                if (!x) ph = PhArmed;
                else if (full && !r) begin ph = PhStuck; e_stuck = 1'b1; e_lvl = x; end
            end
            PhArmed: begin
                if (r) ph = PhMeasuring;
                else if (full) begin ph = PhStuck; e_stuck = 1'b1; e_lvl = x; end
            end
            PhMeasuring: begin
                if (r) begin
                    e_valid  = 1'b1;
                    e_period = (since > MAXV) ? MAXV : since;
                    e_duty   = (ones > MAXV) ? MAXV : ones;
                end else if (full) begin
                    ph = PhStuck; e_stuck = 1'b1; e_lvl = x;
                end
            end
            PhStuck: begin
                if (r) begin ph = PhMeasuring; e_stuck = 1'b0; e_lvl = 1'b0; end
                else e_lvl = x;
            end
            default: ph = PhWaitLow;
        endcase
        if (r) begin
            since = 1;
            ones  = 1;
        end else begin
            since = (since >= MAXV) ? MAXV : since + 1;
            ones  = (ones >= MAXV) ? MAXV : ones + int'(x);
        end
        last = x;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            started = 1'b1;
        end else if (started) begin
            pend.push_back(bus.pwm_in);
            if (pend.size() > 2) model_sample(pend.pop_front());
            else e_valid = 1'b0;
        end
        #1;
        if (started) begin
            check_eq("valid", int'(bus.valid_out), int'(e_valid));
            check_eq("duty", int'(bus.duty_out), e_duty);
            check_eq("period", int'(bus.period_out), e_period);
            check_eq("stuck", int'(bus.stuck_out), int'(e_stuck));
            check_eq("stuck_lvl", int'(bus.stuck_lvl_out), int'(e_lvl));
            check_eq("valid_back_to_back", int'(prev_valid & bus.valid_out), 0);
            prev_valid = bus.valid_out;
            if (bus.valid_out) n_strobes++;
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            bus.pwm_in = v;
            @(negedge clk);
        end
    endtask

    task automatic pwm(input int p, input int h, input int cnt);
        repeat (cnt) begin
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    initial begin
        int p, h;
        prev_valid = 1'b0;
        bus.pwm_in = 1'b0;
        @(negedge clk);
        drive(1'b0, 3);
        rst = 1'b0;

        // Line low at reset, P=10 H=3
        pwm(10, 3, 6);
        // Line stuck high after measuring, then recovery
        drive(1'b1, 40);
        drive(1'b0, 5);
        pwm(10, 3, 3);
        // Period exactly 31, then 32, then 31 again
        pwm(31, 10, 3);
        pwm(32, 10, 2);
        pwm(31, 10, 2);
        // Reset pulse mid-period
        pwm(10, 3, 2);
        drive(1'b1, 2);
        rst = 1'b1;
        drive(1'b1, 1);
        rst = 1'b0;
        drive(1'b0, 7);
        pwm(10, 3, 4);
        // Line high across reset release, P=8 H=5
        rst = 1'b1;
        drive(1'b1, 3);
        rst = 1'b0;
        drive(1'b1, 4);
        drive(1'b0, 3);
        pwm(8, 5, 5);
        // Line high for longer than MAX straight out of reset
        rst = 1'b1;
        drive(1'b1, 2);
        rst = 1'b0;
        drive(1'b1, 40);
        drive(1'b0, 4);
        pwm(8, 5, 3);
        // Minimum period
        pwm(2, 1, 20);
        // Random PWM segments with occasional holds and resets
        repeat (60) begin
            p = $urandom_range(2, 34);
            h = $urandom_range(1, p - 1);
            pwm(p, h, $urandom_range(1, 4));
            case ($urandom_range(0, 9))
                0: drive(1'($urandom_range(0, 1)), $urandom_range(25, 45));
                1: begin
                    rst = 1'b1;
                    drive(1'($urandom_range(0, 1)), $urandom_range(1, 2));
                    rst = 1'b0;
                end
                default: ;
            endcase
        end
        // Unstructured random bit stream
        repeat (300) drive(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        drive(1'b0, 4);

        check_eq("strobes_seen", int'(n_strobes > 50), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
